decoder_2to4: RTL and testbench
===============================

Name: decoder_2to4

Overview:
- Registered 2-to-4 one-hot line decoder.
- Two select bits (x1 = MSB, x2 = LSB) drive exactly one of four output lines a/b/c/d.
- Used as a small address/select decoder in the datapath. Outputs are registered on the single system clock so downstream logic sees glitch-free selects.

Parameters:
- ACTIVE_LOW, 0, output polarity. 0: selected line = 1, others = 0. 1: selected line = 0, others = 1. The idle/reset state is the inverse of "selected" for every line.
- HAS_ENABLE, 1, enable handling. 1: en input gates decoding. 0: en is ignored and treated as constant 1.

Ports:
- clk  input  1  system clock; all state updates on the rising edge
- rst_n  input  1  synchronous, active-low reset; sampled on the rising edge of clk
- en  input  1  decode enable
- x1  input  1  select bit 1 (MSB)
- x2  input  1  select bit 0 (LSB)
- a  output  1  selected when {x1,x2} = 00
- b  output  1  selected when {x1,x2} = 01
- c  output  1  selected when {x1,x2} = 10
- d  output  1  selected when {x1,x2} = 11
- valid  output  1  1 when a/b/c/d carry a decoded (one-hot) value

Behaviour:
- Interface: one clock (clk); reset rst_n is synchronous and active-low.
- Reset:
  - On a rising clk edge with rst_n = 0, all of a/b/c/d go to the idle level (0 when ACTIVE_LOW = 0, 1 when ACTIVE_LOW = 1) and valid goes to 0.
  - Reset has priority over en and over the select inputs.
  - Asserting reset mid-operation clears the outputs at the next edge.
  - The first decode after rst_n returns high appears one edge later.
- Decode:
  - On a rising edge with rst_n = 1 and en = 1, register the one-hot decode of {x1,x2}.
  - 00 selects a, 01 selects b, 10 selects c, 11 selects d.
  - valid = 1.
- Disable:
  - On a rising edge with rst_n = 1 and en = 0, all four lines go to the idle level and valid = 0.
  - Outputs do not hold their previous value.
- Latency: exactly 1 clk cycle from input sample to output. No combinational path from x1/x2/en to outputs.
- Invariant: whenever valid = 1, exactly one line is at the selected level. Whenever valid = 0, all four lines are idle.
- Back-to-back changes: a new select value is taken every cycle with no bubbles. The output follows the input stream delayed by one cycle.
- Unknown inputs: behaviour with X/Z on x1/x2 while en = 1 is undefined. Benches drive only 0/1.
- Integer stimulus: a bench driving an integer into x1 or x2 uses its LSB only. Examples: 2 → 0, 3 → 1.

Test Plan:
- Reset: hold rst_n = 0 for 2 cycles with en = 1, x1 = 1, x2 = 1 → a = b = c = d = 0 and valid = 0 after the first edge (ACTIVE_LOW = 0).
- Exhaustive sweep:
  - Stimulus: rst_n = 1, en = 1, apply {x1,x2} = 00, 01, 10, 11 on consecutive cycles.
  - Response, one cycle later each: {a,b,c,d} = 1000, 0100, 0010, 0001, with valid = 1 throughout.
- Enable gating: en = 0 with {x1,x2} = 10 → next cycle {a,b,c,d} = 0000, valid = 0. Then en = 1 → next cycle 0010, valid = 1.
- Mid-operation reset: stream 11 with en = 1, drop rst_n for one cycle → that edge yields 0000/valid = 0. The following edge returns 0001.
- Polarity: ACTIVE_LOW = 1, {x1,x2} = 01, en = 1 → {a,b,c,d} = 1011. Reset → 1111.
- One-hot check: random select/en/rst_n stimulus for 1000 cycles → the invariant holds every cycle and matches a 1-cycle-delayed reference model.

Source files
------------

// File: rtl/decoder_2to4.sv
// ============================================================================
//  Module   : decoder_2to4
//  Brief    : Registered 2-to-4 one-hot line decoder with selectable output
//             polarity and optional decode enable. Outputs are taken
//             straight from flops so downstream selects are glitch-free.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module decoder_2to4 #(
  parameter bit ACTIVE_LOW = 1'b0,  // 1: selected line driven low, idle high
  parameter bit HAS_ENABLE = 1'b1   // 0: en is ignored and decoding always runs
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic x1,
  input  logic x2,
  output logic a,
  output logic b,
  output logic c,
  output logic d,
  output logic valid
);

  // Idle level of every line; the selected line is the inverse of this.
  localparam logic [3:0] C_IDLE = {4{ACTIVE_LOW}};

  logic       w_en;       // effective decode enable
  logic [3:0] w_onehot;   // active-high one-hot, bit 3 = a ... bit 0 = d
  logic [3:0] w_lines;    // one-hot converted to physical output levels
  logic [3:0] r_lines;    // registered {a,b,c,d}
  logic       r_valid;

  // Enable is either the port or tied high, chosen at elaboration time.
  generate
    if (HAS_ENABLE) begin : g_enable
      assign w_en = en;
    end else begin : g_no_enable
      assign w_en = 1'b1;
    end
  endgenerate

  // Select decode in active-high form; polarity is applied afterwards.
  always_comb begin
    w_onehot = 4'b0000;
    case ({x1, x2})
      2'b00:   w_onehot = 4'b1000;
      2'b01:   w_onehot = 4'b0100;
      2'b10:   w_onehot = 4'b0010;
      2'b11:   w_onehot = 4'b0001;
      default: w_onehot = 4'b0000;
    endcase
  end

  // XOR with the idle pattern flips every line when outputs are active-low,
  // so the register stores the physical level and no logic follows it.
  assign w_lines = w_onehot ^ C_IDLE;

  // Output register: reset beats enable, a disabled cycle forces idle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_lines <= C_IDLE;
      r_valid <= 1'b0;
    end else if (w_en) begin
      r_lines <= w_lines;
      r_valid <= 1'b1;
    end else begin
      r_lines <= C_IDLE;
      r_valid <= 1'b0;
    end
  end

  assign a     = r_lines[3];
  assign b     = r_lines[2];
  assign c     = r_lines[1];
  assign d     = r_lines[0];
  assign valid = r_valid;

endmodule

`default_nettype wire

// File: tb/tb_decoder_2to4.sv
// ============================================================================
//  Module   : tb_decoder_2to4
//  Brief    : Self-checking bench for decoder_2to4. Three instances share the
//             stimulus: active-high with enable, active-low with enable, and
//             active-high with the enable disregarded.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_decoder_2to4;

  logic clk = 1'b0;
  logic rst_n, en, x1, x2;

  logic a0, b0, c0, d0, v0;
  logic a1, b1, c1, d1, v1;
  logic a2, b2, c2, d2, v2;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  decoder_2to4 #(.ACTIVE_LOW(1'b0), .HAS_ENABLE(1'b1)) u_dut_hi (
    .clk(clk), .rst_n(rst_n), .en(en), .x1(x1), .x2(x2),
    .a(a0), .b(b0), .c(c0), .d(d0), .valid(v0)
  );

  decoder_2to4 #(.ACTIVE_LOW(1'b1), .HAS_ENABLE(1'b1)) u_dut_lo (
    .clk(clk), .rst_n(rst_n), .en(en), .x1(x1), .x2(x2),
    .a(a1), .b(b1), .c(c1), .d(d1), .valid(v1)
  );

  decoder_2to4 #(.ACTIVE_LOW(1'b0), .HAS_ENABLE(1'b0)) u_dut_noen (
    .clk(clk), .rst_n(rst_n), .en(en), .x1(x1), .x2(x2),
    .a(a2), .b(b2), .c(c2), .d(d2), .valid(v2)
  );

  // Compare one {a,b,c,d,valid} vector and report a mismatch.
  task automatic check(input string tag, input logic [4:0] got, input logic [4:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got abcd_v=%b_%b expected abcd_v=%b_%b",
               tag, got[4:1], got[0], exp[4:1], exp[0]);
    end
  endtask

  // Apply inputs, let one rising edge pass, then settle away from the edge.
  task automatic step(input logic r, input logic e, input logic s1, input logic s0);
    rst_n = r; en = e; x1 = s1; x2 = s0;
    @(posedge clk);
    #1;
  endtask

  // Reference: expected registered outputs for a given set of sampled inputs.
  function automatic logic [4:0] model(input logic al, input logic he,
                                       input logic r, input logic e,
                                       input logic s1, input logic s0);
    logic [3:0] l;
    logic       v;
    l = 4'b0000;
    v = 1'b0;
    if (r && (e || !he)) begin
      v = 1'b1;
      unique case ({s1, s0})
        2'b00: l = 4'b1000;
        2'b01: l = 4'b0100;
        2'b10: l = 4'b0010;
        2'b11: l = 4'b0001;
      endcase
    end
    if (al) l = ~l;
    return {l, v};
  endfunction

  initial begin
    int iv;
    logic r_r, r_e, r_1, r_0;

    rst_n = 1'b0; en = 1'b1; x1 = 1'b1; x2 = 1'b1;

    // Reset held two cycles with the select pattern active
    step(1'b0, 1'b1, 1'b1, 1'b1);
    check("reset1_hi",  {a0, b0, c0, d0, v0}, 5'b0000_0);
    check("reset1_lo",  {a1, b1, c1, d1, v1}, 5'b1111_0);
    check("reset1_noen",{a2, b2, c2, d2, v2}, 5'b0000_0);
    step(1'b0, 1'b1, 1'b1, 1'b1);
    check("reset2_hi",  {a0, b0, c0, d0, v0}, 5'b0000_0);

    // Back-to-back sweep of all select values
    step(1'b1, 1'b1, 1'b0, 1'b0);
    check("sweep00_hi", {a0, b0, c0, d0, v0}, 5'b1000_1);
    step(1'b1, 1'b1, 1'b0, 1'b1);
    check("sweep01_hi", {a0, b0, c0, d0, v0}, 5'b0100_1);
    check("sweep01_lo", {a1, b1, c1, d1, v1}, 5'b1011_1);
    step(1'b1, 1'b1, 1'b1, 1'b0);
    check("sweep10_hi", {a0, b0, c0, d0, v0}, 5'b0010_1);
    step(1'b1, 1'b1, 1'b1, 1'b1);
    check("sweep11_hi", {a0, b0, c0, d0, v0}, 5'b0001_1);
    check("sweep11_lo", {a1, b1, c1, d1, v1}, 5'b1110_1);

    // Enable gating: disabled cycle goes idle, no hold of previous value
    step(1'b1, 1'b0, 1'b1, 1'b0);
    check("en0_hi",     {a0, b0, c0, d0, v0}, 5'b0000_0);
    check("en0_lo",     {a1, b1, c1, d1, v1}, 5'b1111_0);
    check("en0_noen",   {a2, b2, c2, d2, v2}, 5'b0010_1);
    step(1'b1, 1'b1, 1'b1, 1'b0);
    check("en1_hi",     {a0, b0, c0, d0, v0}, 5'b0010_1);

    // Mid-operation reset while streaming 11
    step(1'b1, 1'b1, 1'b1, 1'b1);
    check("pre_rst_hi", {a0, b0, c0, d0, v0}, 5'b0001_1);
    step(1'b0, 1'b1, 1'b1, 1'b1);
    check("mid_rst_hi", {a0, b0, c0, d0, v0}, 5'b0000_0);
    check("mid_rst_noen",{a2, b2, c2, d2, v2}, 5'b0000_0);
    step(1'b1, 1'b1, 1'b1, 1'b1);
    check("post_rst_hi",{a0, b0, c0, d0, v0}, 5'b0001_1);

    // Integer stimulus only contributes its LSB: 2 -> 0, 3 -> 1
    iv = 2; x1 = iv[0];
    iv = 3; x2 = iv[0];
    rst_n = 1'b1; en = 1'b1;
    @(posedge clk); #1;
    check("int_lsb_hi", {a0, b0, c0, d0, v0}, 5'b0100_1);

    // Random stream checked against the one-cycle-delayed reference
    for (int i = 0; i < 1000; i++) begin
      r_r = ($urandom_range(0, 9) != 0);
      r_e = ($urandom_range(0, 3) != 0);
      r_1 = 1'($urandom_range(0, 1));
      r_0 = 1'($urandom_range(0, 1));
      step(r_r, r_e, r_1, r_0);
      check("rand_hi",   {a0, b0, c0, d0, v0}, model(1'b0, 1'b1, r_r, r_e, r_1, r_0));
      check("rand_lo",   {a1, b1, c1, d1, v1}, model(1'b1, 1'b1, r_r, r_e, r_1, r_0));
      check("rand_noen", {a2, b2, c2, d2, v2}, model(1'b0, 1'b0, r_r, r_e, r_1, r_0));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
